// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial add/subtract controller.
// Holds the FSM state encoding and the default operand width.
package serial_addsub_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_fs_cell.sv
// One-bit combined full adder / full subtractor.
// k=0 produces sum and carry-out; k=1 produces difference and borrow-out.
module fa_fs_cell (
    input  logic k,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    // Borrow propagates when the operand bits are equal, generates on 0-1.
    assign cout = k ? ((~a & b) | (cin & ~p))
                    : ((a & b)  | (cin & p));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial W-bit adder/subtractor: LSB first, one bit per clock through a
// single fa_fs_cell, with a three-state IDLE/RUN/DONE controller.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         k,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         c
);

    localparam int unsigned   CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          k_q;
    logic          cy_q;
    logic [CW-1:0] cnt_q;
    logic [W-2:0]  res_q;
    logic [W-1:0]  s_q;
    logic          c_q;
    logic          busy_q;
    logic          done_q;

    logic          bit_s;
    logic          bit_co;
    logic [W-1:0]  res_d;

    fa_fs_cell u_cell (
        .k    (k_q),
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (cy_q),
        .s    (bit_s),
        .cout (bit_co)
    );

    // Newest cell bit enters at the MSB; after W shifts bit 0 sits at the LSB.
    assign res_d = {bit_s, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        k_q     <= k;
                        cy_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d[W-1:1];
                    cy_q  <= bit_co;
                    if (cnt_q == LAST) begin
                        s_q     <= res_d;
                        c_q     <= bit_co;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign c    = c_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (W=8): directed cases, random
// operations and back-to-back starts against an arithmetic reference model.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;

    int n_cmp;
    int n_err;

    logic [W-1:0] exp_s;
    logic         exp_c;

    serial_addsub_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k     (k),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Plain integer arithmetic: W-bit wrapped result, bit W is carry/borrow.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic op, output logic [W-1:0] r,
                                  output logic co);
        logic [W:0] t;
        if (op) t = {1'b0, x} - {1'b0, y};
        else    t = {1'b0, x} + {1'b0, y};
        r  = t[W-1:0];
        co = t[W];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Entered just after a negedge with the block in IDLE; returns likewise.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ok, input bit poke);
        logic [W-1:0] rs;
        logic         rc;
        model(oa, ob, ok, rs, rc);
        start = 1'b1; a = oa; b = ob; k = ok;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < W; i++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_s_hold", 32'(s), 32'(exp_s));
            check("run_c_hold", 32'(c), 32'(exp_c));
            if (poke) begin
                start = 1'b1; a = W'(1); b = W'(1); k = 1'b0;
            end else begin
                start = 1'b0; a = W'($urandom); b = W'($urandom); k = 1'($urandom);
            end
            @(posedge clk); @(negedge clk);
        end
        exp_s = rs;
        exp_c = rc;
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
        check("end_s", 32'(s), 32'(exp_s));
        check("end_c", 32'(c), 32'(exp_c));
        start = poke;
        @(posedge clk); @(negedge clk);
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_s", 32'(s), 32'(exp_s));
        start = 1'b0;
    endtask

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qk[$];
    logic [W-1:0] rs;
    logic         rc;
    int           ph;

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_s = '0;
        exp_c = 1'b0;

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; k = 1'b0; a = 8'h35; b = 8'h4A;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c", 32'(c), 32'd0);

        // First edge with rst low accepts the pending start.
        rst = 1'b0;
        run_op(8'h35, 8'h4A, 1'b0, 1'b0);
        check("dir_35p4a", 32'(s), 32'h7F);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        check("dir_ffp01_c", 32'(c), 32'd1);
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h10, 8'h01, 1'b1, 1'b0);
        check("dir_10m01", 32'(s), 32'h0F);
        run_op(8'h00, 8'h01, 1'b1, 1'b0);
        check("dir_00m01_c", 32'(c), 32'd1);

        // Start held with other operands throughout RUN and DONE is ignored.
        run_op(8'h35, 8'h4A, 1'b0, 1'b1);
        check("poke_s", 32'(s), 32'h7F);

        // Reset during the 4th RUN cycle aborts without a done pulse.
        start = 1'b1; a = 8'h35; b = 8'h4A; k = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
        end
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        exp_s = '0;
        exp_c = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_c", 32'(c), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'h02, 8'h03, 1'b0, 1'b0);
        check("after_abort", 32'(s), 32'h05);

        // Random operations.
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Start held continuously: one operation every W+2 cycles.
        start = 1'b1; a = W'($urandom); b = W'($urandom); k = 1'($urandom);
        for (int j = 0; j < 5 * (W + 2); j++) begin
            ph = j % (W + 2);
            if (ph == 0) begin
                qa.push_back(a); qb.push_back(b); qk.push_back(k);
            end
            @(posedge clk); @(negedge clk);
            check("cont_busy", 32'(busy), (ph < W) ? 32'd1 : 32'd0);
            check("cont_done", 32'(done), (ph == W) ? 32'd1 : 32'd0);
            if (ph == W && qa.size() > 0) begin
                model(qa.pop_front(), qb.pop_front(), qk.pop_front(), rs, rc);
                check("cont_s", 32'(s), 32'(rs));
                check("cont_c", 32'(c), 32'(rc));
            end
            a = W'($urandom); b = W'($urandom); k = 1'($urandom);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; legal range is 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port k, input, 1 bit: operation select, 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 The block SHALL have ports a and b, input, W bits each: operands; sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse when the result is valid.
REQ-009 The block SHALL have port s, output, W bits: sum or difference.
REQ-010 The block SHALL have port c, output, 1 bit: carry-out on add, borrow-out on subtract.

Function
REQ-011 The block SHALL compute the result bit-serially, LSB first, one bit per cycle, through a single 1-bit full add/sub cell.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the accepting edge SHALL load a, b and k into internal registers, clear the carry/borrow flop and the bit counter, and move to RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 Each RUN edge SHALL consume bit[cnt] of the latched operands, shift the cell result into the result register at its MSB, store the cell's carry/borrow-out, and increment cnt.
REQ-016 The edge processing bit W-1 SHALL copy the result register to s and the final carry/borrow to c, and move to DONE.
REQ-017 The latency SHALL be as follows: busy is high from the accepting edge until edge W after it; done is high for exactly the one cycle following edge W.
REQ-018 DONE SHALL go unconditionally to IDLE on the next edge; minimum start-to-start period is W+2 cycles.
REQ-019 start SHALL be ignored in RUN and DONE, and input changes on a, b or k during RUN SHALL have no effect.
REQ-020 s and c SHALL hold their last value until the next completing edge; they SHALL never show partial results.
REQ-021 Add SHALL follow the cell equations s_i = a_i^b_i^cin and cout = a_i&b_i | cin&(a_i^b_i).
REQ-022 Subtract SHALL follow the cell equations d_i = a_i^b_i^bin and bout = ~a_i&b_i | bin&~(a_i^b_i).
REQ-023 The initial carry/borrow SHALL be 0 for both operations.
REQ-024 Results SHALL wrap modulo 2^W; c reports the overflow or underflow.
REQ-025 The bit counter SHALL be $clog2(W) bits wide and SHALL never exceed W-1.

Reset
REQ-026 With rst=1 at an edge, the next state SHALL be IDLE with busy=0, done=0, s=0, c=0, cnt=0, all internal registers cleared, and reset SHALL take priority over start.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation with no done pulse, and s and c SHALL read 0.
REQ-028 The block SHALL accept start on the first edge with rst=0, provided start=1 and the state is IDLE.

Structure
REQ-029 The package serial_addsub_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default width constant.
REQ-030 The 1-bit cell SHALL be the sub-module fa_fs_cell (inputs k, a, b, cin; outputs s, cout), purely combinational, instantiated exactly once.
REQ-031 All other logic SHALL be in serial_addsub_ctrl, with all outputs registered.

Verification
REQ-032 The bench SHALL cover W=8, k=0, a=0x35, b=0x4A, start one cycle -> busy for 8 cycles, done one cycle later, s=0x7F, c=0.
REQ-033 The bench SHALL cover add a=0xFF, b=0x01 -> s=0x00, c=1; and add a=0x00, b=0x00 -> s=0x00, c=0.
REQ-034 The bench SHALL cover subtract a=0x10, b=0x01 -> s=0x0F, c=0; and subtract a=0x00, b=0x01 -> s=0xFF, c=1.
REQ-035 The bench SHALL cover a second start pulse with a=0x01, b=0x01 during RUN of 0x35+0x4A -> ignored, s=0x7F, exactly one done.
REQ-036 The bench SHALL cover rst asserted at the 4th RUN cycle -> no done, busy=0, s=0, c=0 next cycle; a subsequent 0x02+0x03 -> s=0x05.
REQ-037 The bench SHALL cover start held high continuously -> done pulses spaced W+2=10 cycles apart, with each result matching the operands sampled at its accepting edge.
